mem_io_responder: RTL and testbench

Memory-side responder for the CPU's byte-wide memory bus: the endpoint that receives `mem_a`/`mem_wr`/`mem_dout` from the CPU and returns `mem_din` and `io_buffer_full`. Contains the byte RAM (default 128 KB) and the memory-mapped I/O at 0x30000/0x30004: an input-byte port, a TX FIFO toward the UART, a cycle counter and the program-stop flag. It sits between the CPU top level and the board/UART wrapper, and doubles as the simulation memory model.

---
 rtl/mem_io_responder.sv | 140 ++++++++++++++
 tb/tb_mem_io_responder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// Byte-wide memory responder: RAM plus memory-mapped I/O at 0x30000/0x30004
// (RX byte port, TX FIFO toward the UART, cycle counter and program-stop flag).
module mem_io_responder #(
    parameter int ADDR_WIDTH = 17,
    parameter int TX_DEPTH   = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        io_buffer_full,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        prog_stop,
    output logic        tx_overflow
);
    localparam int PTR_W = $clog2(TX_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]            mem [0:(1 << ADDR_WIDTH) - 1];
    logic [7:0]            fifo_mem [0:TX_DEPTH - 1];

    logic                  io_sel;
    logic [15:0]           io_off;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  unused_addr;

    logic [31:0]           counter;
    logic [31:0]           snapshot;
    logic [7:0]            rdata_next;

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  fifo_full;
    logic                  push_req;
    logic                  push;
    logic                  pop;
    logic [7:0]            push_byte;
    logic                  stop_wr;

    assign io_sel      = (cpu_addr[17:16] == 2'b11);
    assign io_off      = cpu_addr[15:0];
    assign ram_addr    = cpu_addr[ADDR_WIDTH-1:0];
    assign unused_addr = ^cpu_addr[31:18];

    assign rx_ready = !rst_in && io_sel && !cpu_wr && (io_off == 16'h0000);

    assign stop_wr   = io_sel && cpu_wr && !prog_stop && (io_off == 16'h0004);
    assign push_req  = (io_sel && cpu_wr && !prog_stop && (io_off == 16'h0000) && (cpu_wdata != 8'h00))
                       || stop_wr;
    assign push_byte = stop_wr ? 8'h00 : cpu_wdata;
    assign fifo_full = (count == CNT_W'(TX_DEPTH));
    assign pop       = tx_valid && tx_ready;
    // A pop in the same cycle frees a slot, so a push at full is still accepted.
    assign push      = push_req && (!fifo_full || pop);

    assign tx_valid       = (count != '0);
    assign tx_data        = fifo_mem[rd_ptr];
    assign io_buffer_full = (count >= CNT_W'(TX_DEPTH - 2));

    always_comb begin
        rdata_next = cpu_rdata;
        if (!cpu_wr) begin
            if (io_sel) begin
                case (io_off)
                    16'h0000: rdata_next = rx_valid ? rx_data : 8'h00;
                    16'h0004: rdata_next = counter[7:0];
                    16'h0005: rdata_next = snapshot[15:8];
                    16'h0006: rdata_next = snapshot[23:16];
                    16'h0007: rdata_next = snapshot[31:24];
                    default:  rdata_next = 8'h00;
                endcase
            end else begin
                rdata_next = mem[ram_addr];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (cpu_wr && !io_sel) begin
            mem[ram_addr] <= cpu_wdata;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_byte;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cpu_rdata <= 8'h00;
            counter   <= '0;
            snapshot  <= '0;
        end else begin
            cpu_rdata <= rdata_next;
            counter   <= counter + 32'd1;
            if (io_sel && !cpu_wr && (io_off == 16'h0004)) begin
                snapshot <= counter;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            prog_stop   <= 1'b0;
            tx_overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (stop_wr) begin
                prog_stop <= 1'b1;
            end
            if (push_req && fifo_full && !pop) begin
                tx_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: reset, counter snapshot, RAM aliasing,
// RX port, TX FIFO ordering/backpressure/overflow, program stop and reset recovery.
module tb_mem_io_responder;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] cpu_addr;
    logic        cpu_wr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        io_buffer_full;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        prog_stop;
    logic        tx_overflow;

    int checks = 0;
    int errors = 0;

    mem_io_responder #(.ADDR_WIDTH(17), .TX_DEPTH(8)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .cpu_addr(cpu_addr), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .io_buffer_full(io_buffer_full),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .prog_stop(prog_stop), .tx_overflow(tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        cpu_addr = 32'h0000_0010;
        cpu_wr   = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        cpu_addr = a;
        cpu_wr   = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        cpu_addr  = a;
        cpu_wr    = 1'b1;
        cpu_wdata = d;
    endtask

    initial begin
        rst_in = 1'b1; cpu_wdata = 8'h00; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
        idle();
        step();
        // rx_ready must stay low while reset is asserted, even on an RX read
        rd(32'h0003_0000); rx_valid = 1'b1; rx_data = 8'h99;
        #1;
        check("rst_rx_ready", rx_ready, 0);
        step();
        check("rst_rdata", cpu_rdata, 8'h00);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_ibf", io_buffer_full, 0);
        check("rst_stop", prog_stop, 0);
        check("rst_ovf", tx_overflow, 0);

        // Counter: 0 after the last reset edge, 300 after 300 more edges
        rst_in = 1'b0; rx_valid = 1'b0; idle();
        repeat (300) step();
        rd(32'h0003_0004); step();
        check("cnt_byte0", cpu_rdata, 8'h2C);
        idle();
        repeat (9) step();
        rd(32'h0003_0005); step();
        check("snap_byte1", cpu_rdata, 8'h01);
        rd(32'h0003_0006); step();
        check("snap_byte2", cpu_rdata, 8'h00);
        rd(32'h0003_0007); step();
        check("snap_byte3", cpu_rdata, 8'h00);
        idle();
        repeat (250) step();
        rd(32'h0003_0005); step();
        check("snap_held", cpu_rdata, 8'h01);
        rd(32'h0003_0008); step();
        check("io_other_rd", cpu_rdata, 8'h00);

        // RAM write/read and aliasing
        wr(32'h0000_0010, 8'h5A); step();
        rd(32'h0000_0010); step();
        check("ram_rd", cpu_rdata, 8'h5A);
        rd(32'h0002_0010); step();
        check("ram_alias", cpu_rdata, 8'h5A);
        wr(32'h0001_FFFF, 8'hA5); step();
        rd(32'hFFFD_FFFF); step();
        check("ram_top_alias", cpu_rdata, 8'hA5);

        // RX port
        rx_valid = 1'b1; rx_data = 8'h37; rd(32'h0003_0000);
        #1;
        check("rx_ready_hi", rx_ready, 1);
        step();
        check("rx_data", cpu_rdata, 8'h37);
        rx_valid = 1'b0; rx_data = 8'h55;
        step();
        check("rx_empty", cpu_rdata, 8'h00);
        idle();
        #1;
        check("rx_ready_lo", rx_ready, 0);

        // TX ordering, zero byte suppressed
        tx_ready = 1'b1;
        wr(32'h0003_0000, 8'h41); step();
        check("tx_v_41", tx_valid, 1);
        check("tx_d_41", tx_data, 8'h41);
        wr(32'h0003_0000, 8'h00); step();
        check("tx_zero_dropped", tx_valid, 0);
        wr(32'h0003_0000, 8'h42); step();
        check("tx_d_42", tx_data, 8'h42);
        idle(); step();
        check("tx_drained", tx_valid, 0);

        // Backpressure
        tx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            wr(32'h0003_0000, 8'(i)); step();
        end
        check("ibf_at5", io_buffer_full, 0);
        wr(32'h0003_0000, 8'h06); step();
        check("ibf_at6", io_buffer_full, 1);
        wr(32'h0003_0000, 8'h07); step();
        wr(32'h0003_0000, 8'h08); step();
        check("ovf_at8", tx_overflow, 0);
        check("head_at8", tx_data, 8'h01);
        tx_ready = 1'b1;
        wr(32'h0003_0000, 8'h0A); step();
        check("ovf_pushpop_full", tx_overflow, 0);
        check("head_after_pop", tx_data, 8'h02);
        tx_ready = 1'b0;
        wr(32'h0003_0000, 8'h0B); step();
        check("ovf_set", tx_overflow, 1);
        idle(); step();
        check("ovf_sticky", tx_overflow, 1);
        // Pop three: remaining 02..08,0A, count 8 -> 5
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("drain_valid", tx_valid, 1);
            check("drain_data", tx_data, 8'(i + 2));
            check("drain_ibf", io_buffer_full, (8 - i) >= 6);
            step();
        end
        check("ibf_at5_drain", io_buffer_full, 0);
        check("drain_data4", tx_data, 8'h05);

        // Reset mid-stream clears FIFO and flags, preserves RAM
        tx_ready = 1'b0; rst_in = 1'b1; step();
        rst_in = 1'b0;
        check("rst2_tx_valid", tx_valid, 0);
        check("rst2_ovf", tx_overflow, 0);
        check("rst2_ibf", io_buffer_full, 0);
        check("rst2_rdata", cpu_rdata, 8'h00);

        // Program stop
        wr(32'h0003_0004, 8'hFF); step();
        check("stop_set", prog_stop, 1);
        check("stop_marker_v", tx_valid, 1);
        check("stop_marker_d", tx_data, 8'h00);
        wr(32'h0003_0000, 8'h43); step();
        tx_ready = 1'b1; idle(); step();
        check("stop_ignored_wr", tx_valid, 0);
        check("stop_sticky", prog_stop, 1);
        tx_ready = 1'b0;
        wr(32'h0000_0020, 8'h77); step();
        rd(32'h0000_0020); step();
        check("stop_ram_ok", cpu_rdata, 8'h77);
        rst_in = 1'b1; idle(); step();
        rst_in = 1'b0;
        check("rst3_stop", prog_stop, 0);
        check("rst3_tx_valid", tx_valid, 0);
        rd(32'h0000_0010); step();
        check("ram_kept", cpu_rdata, 8'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
